// File: rtl/fc_stream_bridge.sv
// Host-side bridge for an fc_* layer: serializes a parallel input vector onto the
// layer's input stream and collects the layer's serial output into a parallel result.
module fc_stream_bridge #(
  parameter int WIDTH   = 16,
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int MAX_OUT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vec_valid,
  output logic                    vec_ready,
  input  logic [N*WIDTH-1:0]      vec_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic signed [WIDTH-1:0] tx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic signed [WIDTH-1:0] rx_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [M*WIDTH-1:0]      res_data
);

  localparam int TIW = (N > 1) ? $clog2(N) : 1;
  localparam int RIW = (M > 1) ? $clog2(M) : 1;
  localparam int PW  = $clog2(MAX_OUT + 1);

  typedef enum logic {T_IDLE = 1'b0, T_SEND = 1'b1} tx_state_t;
  typedef enum logic {R_COLLECT = 1'b0, R_HOLD = 1'b1} rx_state_t;

  tx_state_t        r_tx_state;
  rx_state_t        r_rx_state;
  logic [TIW-1:0]   r_tx_idx;
  logic [RIW-1:0]   r_rx_idx;
  logic [PW-1:0]    r_pend;
  logic [WIDTH-1:0] r_tx_buf [N];
  logic [WIDTH-1:0] r_rx_buf [M];

  logic w_vec_hs;
  logic w_tx_hs;
  logic w_rx_hs;
  logic w_res_hs;

  // Every output is a decode of registered state, so no input reaches an output
  // combinationally and both stream ports can be chained without timing loops.
  assign vec_ready = (r_tx_state == T_IDLE) && (r_pend < PW'(MAX_OUT));
  assign tx_valid  = (r_tx_state == T_SEND);
  assign tx_data   = r_tx_buf[r_tx_idx];
  assign rx_ready  = (r_rx_state == R_COLLECT);
  assign res_valid = (r_rx_state == R_HOLD);

  for (genvar j = 0; j < M; j++) begin : g_res_pack
    assign res_data[j*WIDTH +: WIDTH] = r_rx_buf[j];
  end

  assign w_vec_hs = vec_valid && vec_ready;
  assign w_tx_hs  = tx_valid  && tx_ready;
  assign w_rx_hs  = rx_valid  && rx_ready;
  assign w_res_hs = res_valid && res_ready;

  // NOTE: state registers use non-blocking assignments so every always_ff reads
  // the pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= T_IDLE;
      r_tx_idx   <= '0;
      // NOTE: the data buffers are reset explicitly because reset must discard
      // stale contents and tx_data/res_data have defined reset values of zero.
      for (int i = 0; i < N; i++) r_tx_buf[i] <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (w_vec_hs) begin
            for (int i = 0; i < N; i++) r_tx_buf[i] <= vec_data[i*WIDTH +: WIDTH];
            r_tx_idx   <= '0;
            r_tx_state <= T_SEND;
          end
        end
        T_SEND: begin
          if (w_tx_hs) begin
            if (r_tx_idx == TIW'(N - 1)) begin
              r_tx_idx   <= '0;
              r_tx_state <= T_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
            end
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= R_COLLECT;
      r_rx_idx   <= '0;
      for (int j = 0; j < M; j++) r_rx_buf[j] <= '0;
    end else begin
      case (r_rx_state)
        R_COLLECT: begin
          if (w_rx_hs) begin
            r_rx_buf[r_rx_idx] <= rx_data;
            if (r_rx_idx == RIW'(M - 1)) begin
              r_rx_state <= R_HOLD;
            end else begin
              r_rx_idx <= r_rx_idx + 1'b1;
            end
          end
        end
        R_HOLD: begin
          if (w_res_hs) begin
            r_rx_idx   <= '0;
            r_rx_state <= R_COLLECT;
          end
        end
        default: r_rx_state <= R_COLLECT;
      endcase
    end
  end

  // In-flight credit: results arriving with nothing outstanding leave it at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else if (w_vec_hs && !w_res_hs) begin
      r_pend <= r_pend + 1'b1;
    end else if (w_res_hs && !w_vec_hs && (r_pend != '0)) begin
      r_pend <= r_pend - 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_pend_bound: assert property (@(posedge clk) disable iff (reset)
    r_pend <= PW'(MAX_OUT));
  a_tx_hold: assert property (@(posedge clk) disable iff (reset)
    (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data)));
  a_res_hold: assert property (@(posedge clk) disable iff (reset)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data)));
`endif

endmodule

// File: tb/tb_fc_stream_bridge.sv
// Self-checking bench for fc_stream_bridge: randomized streams compared against a
// queue-based transaction model of the bridge.
module tb_fc_stream_bridge;

  localparam int WIDTH   = 16;
  localparam int N       = 8;
  localparam int M       = 8;
  localparam int MAX_OUT = 2;

  logic                    clk;
  logic                    reset;
  logic                    vec_valid;
  logic                    vec_ready;
  logic [N*WIDTH-1:0]      vec_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic signed [WIDTH-1:0] tx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic signed [WIDTH-1:0] rx_data;
  logic                    res_valid;
  logic                    res_ready;
  logic [M*WIDTH-1:0]      res_data;

  int n_checks = 0;
  int n_fail   = 0;

  fc_stream_bridge #(.WIDTH(WIDTH), .N(N), .M(M), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: words still owed on TX, outstanding credit, words collected.
  logic [WIDTH-1:0] m_tx_q[$];
  logic [WIDTH-1:0] m_rx_q[$];
  logic [WIDTH-1:0] m_res[M];
  int               m_pend;
  bit               m_hold;

  function automatic bit m_vec_ready();
    return (m_tx_q.size() == 0) && (m_pend < MAX_OUT);
  endfunction

  function automatic logic [M*WIDTH-1:0] m_res_word();
    logic [M*WIDTH-1:0] r;
    for (int j = 0; j < M; j++) r[j*WIDTH +: WIDTH] = m_res[j];
    return r;
  endfunction

  function automatic logic [N*WIDTH-1:0] rand_vec();
    logic [N*WIDTH-1:0] r;
    for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  // Advance one clock; the model decides handshakes from its own view of the bridge.
  task automatic tick();
    bit hv, ht, hr, hs;
    hv = vec_valid && m_vec_ready();
    ht = (m_tx_q.size() != 0) && tx_ready;
    hr = !m_hold && rx_valid;
    hs = m_hold && res_ready;
    @(posedge clk);
    if (reset) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_hold = 1'b0;
      m_pend = 0;
      for (int j = 0; j < M; j++) m_res[j] = '0;
    end else begin
      if (ht) void'(m_tx_q.pop_front());
      if (hv) for (int i = 0; i < N; i++) m_tx_q.push_back(vec_data[i*WIDTH +: WIDTH]);
      if (hr) begin
        m_rx_q.push_back(rx_data);
        if (m_rx_q.size() == M) begin
          m_hold = 1'b1;
          for (int j = 0; j < M; j++) m_res[j] = m_rx_q[j];
        end
      end
      if (hs) begin
        m_hold = 1'b0;
        m_rx_q.delete();
      end
      if (hv && !hs) m_pend++;
      else if (hs && !hv && m_pend > 0) m_pend--;
    end
    @(negedge clk);
  endtask

  task automatic send_vec(input logic [N*WIDTH-1:0] v);
    int budget = 50;
    vec_data  = v;
    vec_valid = 1'b1;
    while (!m_vec_ready() && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_fail++;
      $display("FAIL send_vec_timeout: vec_ready=%0b after 50 cycles, required 1", vec_ready);
    end
    n_checks++;
    tick();
    vec_valid = 1'b0;
  endtask

  task automatic drain_tx();
    tx_ready = 1'b1;
    for (int i = 0; i < N && m_tx_q.size() != 0; i++) tick();
    tx_ready = 1'b0;
  endtask

  task automatic return_result(input logic [M*WIDTH-1:0] w);
    for (int j = 0; j < M; j++) begin
      rx_data  = w[j*WIDTH +: WIDTH];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    vec_valid = 0; vec_data = '0; tx_ready = 0; rx_valid = 0; rx_data = '0; res_ready = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    if ({vec_ready, tx_valid, rx_ready, res_valid} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_flags: vr/tv/rr/rv=%b required 1010",
               {vec_ready, tx_valid, rx_ready, res_valid});
    end
    n_checks++;
    if (tx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_tx_data: got %0h required 0", tx_data);
    end
    n_checks++;
    if (res_data !== '0) begin
      n_fail++;
      $display("FAIL reset_res_data: got %h required 0", res_data);
    end
    n_checks++;
  endtask

  task automatic test_basic();
    logic [N*WIDTH-1:0] v;
    logic [M*WIDTH-1:0] exp_res;
    for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    for (int j = 0; j < M; j++) exp_res[j*WIDTH +: WIDTH] = WIDTH'(10 * (j + 1));
    vec_data  = v;
    vec_valid = 1'b1;
    tx_ready  = 1'b1;
    tick();
    vec_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ({tx_valid, tx_data} !== {1'b1, WIDTH'(i + 1)}) begin
        n_fail++;
        $display("FAIL basic_tx[%0d]: valid=%0b data=%0d required valid=1 data=%0d",
                 i, tx_valid, tx_data, i + 1);
      end
      n_checks++;
      tick();
    end
    tx_ready = 1'b0;
    if ({tx_valid, vec_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_tx_done: tx_valid/vec_ready=%b required 01", {tx_valid, vec_ready});
    end
    n_checks++;
    for (int j = 0; j < M; j++) begin
      rx_data  = WIDTH'(10 * (j + 1));
      rx_valid = 1'b1;
      if ({rx_ready, res_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL basic_rx[%0d]: rx_ready/res_valid=%b required 10", j, {rx_ready, res_valid});
      end
      n_checks++;
      tick();
    end
    rx_valid = 1'b0;
    if ({res_valid, rx_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_res_flags: res_valid/rx_ready=%b required 10", {res_valid, rx_ready});
    end
    n_checks++;
    if (res_data !== exp_res) begin
      n_fail++;
      $display("FAIL basic_res_data: got %h required %h", res_data, exp_res);
    end
    n_checks++;
    accept_result();
    if ({rx_ready, res_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_after_res: rx_ready/res_valid=%b required 10", {rx_ready, res_valid});
    end
    n_checks++;
  endtask

  task automatic test_tx_backpressure();
    for (int v = 0; v < 3; v++) begin
      logic [N*WIDTH-1:0] vec;
      logic [WIDTH-1:0]   obs[$];
      logic [WIDTH-1:0]   prev_data;
      bit                 prev_stall;
      int                 budget;
      vec = rand_vec();
      send_vec(vec);
      prev_stall = 1'b0;
      prev_data  = '0;
      budget     = 200;
      while (m_tx_q.size() != 0 && budget > 0) begin
        tx_ready = 1'($urandom_range(0, 1));
        if (prev_stall && tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL bp_hold: tx_data=%h changed during stall, required %h", tx_data, prev_data);
        end
        if ({tx_valid, tx_data} !== {1'b1, m_tx_q[0]}) begin
          n_fail++;
          $display("FAIL bp_word: valid=%0b data=%h required valid=1 data=%h",
                   tx_valid, tx_data, m_tx_q[0]);
        end
        n_checks++;
        if (tx_valid && tx_ready) obs.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        tick();
        budget--;
      end
      tx_ready = 1'b0;
      if (obs.size() != N) begin
        n_fail++;
        $display("FAIL bp_count: %0d tx handshakes, required %0d", obs.size(), N);
      end else begin
        for (int i = 0; i < N; i++) begin
          if (obs[i] !== vec[i*WIDTH +: WIDTH]) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got %h required %h", i, obs[i], vec[i*WIDTH +: WIDTH]);
          end
        end
      end
      n_checks++;
      budget = 200;
      while (!m_hold && budget > 0) begin
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = WIDTH'($urandom);
        tick();
        budget--;
      end
      rx_valid = 1'b0;
      if ({res_valid, res_data} !== {1'b1, m_res_word()}) begin
        n_fail++;
        $display("FAIL bp_result: valid=%0b data=%h required valid=1 data=%h",
                 res_valid, res_data, m_res_word());
      end
      n_checks++;
      accept_result();
    end
  endtask

  task automatic test_rx_hold();
    logic [M*WIDTH-1:0] exp_res;
    send_vec(rand_vec());
    drain_tx();
    return_result(M*WIDTH'($urandom) ^ {M{WIDTH'($urandom)}});
    exp_res  = m_res_word();
    rx_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rx_data = WIDTH'($urandom);
      if ({rx_ready, res_valid, res_data} !== {2'b01, exp_res}) begin
        n_fail++;
        $display("FAIL hold[%0d]: rx_ready=%0b res_valid=%0b data=%h required 0/1/%h",
                 c, rx_ready, res_valid, res_data, exp_res);
      end
      n_checks++;
      tick();
    end
    rx_valid = 1'b0;
    accept_result();
    if ({rx_ready, res_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_release: rx_ready/res_valid=%b required 10", {rx_ready, res_valid});
    end
    n_checks++;
  endtask

  task automatic test_credit_limit();
    send_vec(rand_vec());
    drain_tx();
    send_vec(rand_vec());
    drain_tx();
    vec_data  = rand_vec();
    vec_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (vec_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL credit_refuse[%0d]: vec_ready=%0b required 0", c, vec_ready);
      end
      n_checks++;
      tick();
    end
    return_result({M{WIDTH'($urandom)}});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vec_valid = 1'b0;
    if (vec_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_release: vec_ready=%0b required 1", vec_ready);
    end
    n_checks++;
    return_result({M{WIDTH'($urandom)}});
    vec_valid = 1'b1;
    res_ready = 1'b1;
    if ({vec_ready, res_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL credit_both_pre: vec_ready/res_valid=%b required 11", {vec_ready, res_valid});
    end
    n_checks++;
    tick();
    vec_valid = 1'b0;
    res_ready = 1'b0;
    if ({tx_valid, rx_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL credit_both_post: tx_valid/rx_ready=%b required 11", {tx_valid, rx_ready});
    end
    n_checks++;
    drain_tx();
    if (vec_ready !== 1'b1 || vec_ready !== m_vec_ready()) begin
      n_fail++;
      $display("FAIL credit_pend_kept: vec_ready=%0b required 1", vec_ready);
    end
    n_checks++;
    send_vec(rand_vec());
    drain_tx();
    if (vec_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_full_again: vec_ready=%0b required 0", vec_ready);
    end
    n_checks++;
    return_result({M{WIDTH'($urandom)}});
    accept_result();
    return_result({M{WIDTH'($urandom)}});
    accept_result();
    if (vec_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_drained: vec_ready=%0b required 1", vec_ready);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    logic [N*WIDTH-1:0] v2;
    logic [M*WIDTH-1:0] r2;
    send_vec(rand_vec());
    for (int c = 0; c < 5; c++) begin
      tx_ready = (c < 3);
      rx_valid = 1'b1;
      rx_data  = WIDTH'($urandom);
      tick();
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    if ({tx_valid, res_valid, vec_ready, rx_ready} !== 4'b0011) begin
      n_fail++;
      $display("FAIL midreset_flags: tv/rv/vr/rr=%b required 0011",
               {tx_valid, res_valid, vec_ready, rx_ready});
    end
    n_checks++;
    v2 = rand_vec();
    send_vec(v2);
    tx_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if ({tx_valid, tx_data} !== {1'b1, v2[i*WIDTH +: WIDTH]}) begin
        n_fail++;
        $display("FAIL midreset_tx[%0d]: valid=%0b data=%h required 1/%h",
                 i, tx_valid, tx_data, v2[i*WIDTH +: WIDTH]);
      end
      n_checks++;
      tick();
    end
    tx_ready = 1'b0;
    for (int j = 0; j < M; j++) r2[j*WIDTH +: WIDTH] = WIDTH'($urandom);
    return_result(r2);
    if ({res_valid, res_data} !== {1'b1, r2}) begin
      n_fail++;
      $display("FAIL midreset_res: valid=%0b data=%h required 1/%h", res_valid, res_data, r2);
    end
    n_checks++;
    accept_result();
  endtask

  initial begin
    m_pend = 0;
    m_hold = 1'b0;
    for (int j = 0; j < M; j++) m_res[j] = '0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_tx_backpressure();
    test_rx_hold();
    test_credit_limit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
